decode_stage: RTL and testbench



---
 rtl/core_pkg.sv | 55 +++++
 rtl/decode_stage_if.sv | 38 +++
 rtl/inst_decoder.sv | 60 ++++++
 rtl/decode_stage.sv | 111 +++++++++++
 tb/tb_decode_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcode classes, major opcodes, immediate formats
// and the immediate assembly helper.
package core_pkg;

    typedef enum logic [3:0] {
        OPC_ILLEGAL = 4'd0,
        OPC_LUI     = 4'd1,
        OPC_AUIPC   = 4'd2,
        OPC_JAL     = 4'd3,
        OPC_JALR    = 4'd4,
        OPC_BRANCH  = 4'd5,
        OPC_LOAD    = 4'd6,
        OPC_STORE   = 4'd7,
        OPC_OPIMM   = 4'd8,
        OPC_OP      = 4'd9,
        OPC_FENCE   = 4'd10,
        OPC_SYSTEM  = 4'd11
    } opc_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Reassembles the scattered immediate bits; B and J offsets are halfword aligned.
    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e imm_type);
        logic [31:0] imm;
        case (imm_type)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake plus the ID/EX register contents seen by execute.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int ID_W = 64
);
    logic            if_valid;
    logic [XLEN-1:0] if_reg_pc;
    logic [31:0]     if_inst;
    logic [ID_W-1:0] if_inst_id;
    logic            if_stall_flg;
    logic            ex_stall;
    logic            branch_hazard;

    logic            id_valid;
    logic [XLEN-1:0] id_reg_pc;
    logic [31:0]     id_inst;
    logic [ID_W-1:0] id_inst_id;
    core_pkg::opc_e  id_op;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_imm;
    logic            id_illegal;

    modport master (
        output if_valid, if_reg_pc, if_inst, if_inst_id, ex_stall, branch_hazard,
        input  if_stall_flg, id_valid, id_reg_pc, id_inst, id_inst_id, id_op,
               id_funct3, id_funct7, id_rs1, id_rs2, id_rd, id_imm, id_illegal
    );

    modport slave (
        input  if_valid, if_reg_pc, if_inst, if_inst_id, ex_stall, branch_hazard,
        output if_stall_flg, id_valid, id_reg_pc, id_inst, id_inst_id, id_op,
               id_funct3, id_funct7, id_rs1, id_rs2, id_rd, id_imm, id_illegal
    );
endinterface

// File: rtl/inst_decoder.sv
// Purely combinational RV32I field decoder; register indices a format does not
// use are forced to zero so hazard logic can compare them blindly.
module inst_decoder
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output opc_e            op,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    imm_type_e   imm_type;
    logic        writes_rd;
    logic [31:0] imm32;

    always_comb begin
        op        = OPC_ILLEGAL;
        imm_type  = IMM_NONE;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (inst[6:0])
            OPCODE_LUI:    begin op = OPC_LUI;    imm_type = IMM_U; writes_rd = 1'b1; end
            OPCODE_AUIPC:  begin op = OPC_AUIPC;  imm_type = IMM_U; writes_rd = 1'b1; end
            OPCODE_JAL:    begin op = OPC_JAL;    imm_type = IMM_J; writes_rd = 1'b1; end
            OPCODE_JALR:   begin op = OPC_JALR;   imm_type = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OPCODE_BRANCH: begin op = OPC_BRANCH; imm_type = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPCODE_LOAD:   begin op = OPC_LOAD;   imm_type = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OPCODE_STORE:  begin op = OPC_STORE;  imm_type = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPCODE_OPIMM:  begin op = OPC_OPIMM;  imm_type = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OPCODE_OP:     begin op = OPC_OP;     uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OPCODE_FENCE:  begin op = OPC_FENCE; end
            OPCODE_SYSTEM: begin op = OPC_SYSTEM; imm_type = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
            default:       illegal = 1'b1;
        endcase
        // Compressed encodings are not supported, so any non-11 low pair is rejected outright.
        if (inst[1:0] != 2'b11) begin
            op        = OPC_ILLEGAL;
            imm_type  = IMM_NONE;
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
            writes_rd = 1'b0;
            illegal   = 1'b1;
        end
    end

    assign rs1   = uses_rs1  ? inst[19:15] : 5'd0;
    assign rs2   = uses_rs2  ? inst[24:20] : 5'd0;
    assign rd    = writes_rd ? inst[11:7]  : 5'd0;
    assign imm32 = gen_imm(inst, imm_type);
    assign imm   = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the fetched instruction into the ID/EX register and raises
// back-pressure to fetch on downstream stall or load-use hazard.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    opc_e            dec_op;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            load_use;

    logic            id_valid_reg;
    logic [XLEN-1:0] id_reg_pc_reg;
    logic [31:0]     id_inst_reg;
    logic [ID_W-1:0] id_inst_id_reg;
    opc_e            id_op_reg;
    logic [2:0]      id_funct3_reg;
    logic [6:0]      id_funct7_reg;
    logic [4:0]      id_rs1_reg;
    logic [4:0]      id_rs2_reg;
    logic [4:0]      id_rd_reg;
    logic [XLEN-1:0] id_imm_reg;
    logic            id_illegal_reg;

    inst_decoder #(.XLEN(XLEN)) u_inst_decoder (
        .inst     (bus.if_inst),
        .op       (dec_op),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    // A load writing x0 never produces data, so it can never create a hazard.
    always_comb begin
        load_use = 1'b0;
        if (id_valid_reg && (id_op_reg == OPC_LOAD) && (id_rd_reg != 5'd0) && bus.if_valid) begin
            if ((dec_uses_rs1 && (dec_rs1 == id_rd_reg)) ||
                (dec_uses_rs2 && (dec_rs2 == id_rd_reg))) begin
                load_use = 1'b1;
            end
        end
    end

    assign bus.if_stall_flg = bus.ex_stall | load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_reg   <= 1'b0;
            id_reg_pc_reg  <= '0;
            id_inst_reg    <= '0;
            id_inst_id_reg <= '0;
            id_op_reg      <= OPC_ILLEGAL;
            id_funct3_reg  <= '0;
            id_funct7_reg  <= '0;
            id_rs1_reg     <= '0;
            id_rs2_reg     <= '0;
            id_rd_reg      <= '0;
            id_imm_reg     <= '0;
            id_illegal_reg <= 1'b0;
        end else if (bus.branch_hazard) begin
            // Flush outranks a downstream stall: the wrong-path instruction must die.
            id_valid_reg <= 1'b0;
        end else if (bus.ex_stall) begin
            // Execute is busy; the whole ID/EX register holds.
        end else if (load_use) begin
            id_valid_reg <= 1'b0;
        end else begin
            id_valid_reg   <= bus.if_valid;
            id_reg_pc_reg  <= bus.if_reg_pc;
            id_inst_reg    <= bus.if_inst;
            id_inst_id_reg <= bus.if_inst_id;
            id_op_reg      <= dec_op;
            id_funct3_reg  <= bus.if_inst[14:12];
            id_funct7_reg  <= bus.if_inst[31:25];
            id_rs1_reg     <= dec_rs1;
            id_rs2_reg     <= dec_rs2;
            id_rd_reg      <= dec_rd;
            id_imm_reg     <= dec_imm;
            id_illegal_reg <= dec_illegal;
        end
    end

    assign bus.id_valid   = id_valid_reg;
    assign bus.id_reg_pc  = id_reg_pc_reg;
    assign bus.id_inst    = id_inst_reg;
    assign bus.id_inst_id = id_inst_id_reg;
    assign bus.id_op      = id_op_reg;
    assign bus.id_funct3  = id_funct3_reg;
    assign bus.id_funct7  = id_funct7_reg;
    assign bus.id_rs1     = id_rs1_reg;
    assign bus.id_rs2     = id_rs2_reg;
    assign bus.id_rd      = id_rd_reg;
    assign bus.id_imm     = id_imm_reg;
    assign bus.id_illegal = id_illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued as each
// instruction is presented and compared against what the stage registers.
module tb_decode_stage;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int ID_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .ID_W(ID_W)) bus ();

    decode_stage #(.XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] iid;
    } id_t;

    typedef struct {
        string name;
        id_t   v;
        bit    full;
    } sb_t;

    sb_t sb_q[$];
    id_t obs_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093;
    localparam logic [31:0] I_LW_X5  = 32'h0001_2283;
    localparam logic [31:0] I_ADD    = 32'h0012_8333;
    localparam logic [31:0] I_LW_X0  = 32'h0001_2003;
    localparam logic [31:0] I_ADD_X0 = 32'h0010_0333;
    localparam logic [31:0] I_SW     = 32'h0011_2623;
    localparam logic [31:0] I_LUI    = 32'h1234_50B7;

    function automatic id_t mk(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [63:0] iid, input logic [3:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic ill);
        id_t e;
        e.valid = valid; e.op = op; e.f3 = inst[14:12]; e.f7 = inst[31:25];
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ill = ill;
        e.pc = pc; e.inst = inst; e.iid = iid;
        return e;
    endfunction

    function automatic id_t sample();
        id_t o;
        o.valid = bus.id_valid; o.op = bus.id_op; o.f3 = bus.id_funct3; o.f7 = bus.id_funct7;
        o.rd = bus.id_rd; o.rs1 = bus.id_rs1; o.rs2 = bus.id_rs2; o.imm = bus.id_imm;
        o.ill = bus.id_illegal; o.pc = bus.id_reg_pc; o.inst = bus.id_inst; o.iid = bus.id_inst_id;
        return o;
    endfunction

    task automatic push(input string name, input id_t v, input bit full);
        sb_t e;
        e.name = name; e.v = v; e.full = full;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [63:0] iid);
        bus.if_valid   = v;
        bus.if_reg_pc  = pc;
        bus.if_inst    = inst;
        bus.if_inst_id = iid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ex_stall = 1'b0;
        bus.branch_hazard = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 64'd0);
        push("reset_a", '0, 1'b1);
        tick();
        push("reset_b", '0, 1'b1);
        tick();
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %b expected 0", bus.if_stall_flg);
        end
        rst = 1'b0;
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_pass_through();
        drive(1'b1, 32'h100, I_ADDI, 64'h11);
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL pass_stall: got %b expected 0", bus.if_stall_flg);
        end
        push("pass_addi", mk(1'b1, I_ADDI, 32'h100, 64'h11, OPC_OPIMM, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0), 1'b1);
        tick();
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_back_to_back_imm();
        logic [31:0] insts [4];
        logic [3:0]  ops   [4];
        logic [4:0]  rds   [4];
        logic [4:0]  rs1s  [4];
        logic [4:0]  rs2s  [4];
        logic [31:0] imms  [4];
        insts = '{32'hFE00_0EE3, I_LUI, 32'h0080_006F, I_SW};
        ops   = '{OPC_BRANCH, OPC_LUI, OPC_JAL, OPC_STORE};
        rds   = '{5'd0, 5'd1, 5'd0, 5'd0};
        rs1s  = '{5'd0, 5'd0, 5'd0, 5'd2};
        rs2s  = '{5'd0, 5'd0, 5'd0, 5'd1};
        imms  = '{32'hFFFF_FFFC, 32'h1234_5000, 32'd8, 32'd12};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), insts[i], 64'h20 + 64'(i));
            n_checks++;
            if (bus.if_stall_flg !== 1'b0) begin
                n_errors++;
                $display("FAIL imm_stall[%0d]: got %b expected 0", i, bus.if_stall_flg);
            end
            push($sformatf("imm[%0d]", i), mk(1'b1, insts[i], 32'h200 + 32'(4 * i), 64'h20 + 64'(i),
                 ops[i], rds[i], rs1s[i], rs2s[i], imms[i], 1'b0), 1'b1);
            tick();
        end
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        id_t lw_e;
        lw_e = mk(1'b1, I_LW_X5, 32'h300, 64'h30, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'd0, 1'b0);
        drive(1'b1, 32'h300, I_LW_X5, 64'h30);
        push("lu_lw", lw_e, 1'b1);
        tick();
        drive(1'b1, 32'h304, I_ADD, 64'h31);
        n_checks++;
        if (bus.if_stall_flg !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_stall: got %b expected 1", bus.if_stall_flg);
        end
        lw_e.valid = 1'b0;
        push("lu_bubble", lw_e, 1'b1);
        tick();
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_release: got %b expected 0", bus.if_stall_flg);
        end
        push("lu_add", mk(1'b1, I_ADD, 32'h304, 64'h31, OPC_OP, 5'd6, 5'd5, 5'd1, 32'd0, 1'b0), 1'b1);
        tick();
        drive(1'b1, 32'h308, I_LW_X0, 64'h32);
        push("lu_lw_x0", mk(1'b1, I_LW_X0, 32'h308, 64'h32, OPC_LOAD, 5'd0, 5'd2, 5'd0, 32'd0, 1'b0), 1'b1);
        tick();
        drive(1'b1, 32'h30C, I_ADD_X0, 64'h33);
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_x0_stall: got %b expected 0", bus.if_stall_flg);
        end
        push("lu_add_x0", mk(1'b1, I_ADD_X0, 32'h30C, 64'h33, OPC_OP, 5'd6, 5'd0, 5'd1, 32'd0, 1'b0), 1'b1);
        tick();
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_ex_stall();
        id_t addi_e;
        addi_e = mk(1'b1, I_ADDI, 32'h400, 64'h40, OPC_OPIMM, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        drive(1'b1, 32'h400, I_ADDI, 64'h40);
        push("exs_addi", addi_e, 1'b1);
        tick();
        bus.ex_stall = 1'b1;
        drive(1'b1, 32'h404, I_SW, 64'h41);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.if_stall_flg !== 1'b1) begin
                n_errors++;
                $display("FAIL exs_stall[%0d]: got %b expected 1", k, bus.if_stall_flg);
            end
            push($sformatf("exs_hold[%0d]", k), addi_e, 1'b1);
            tick();
        end
        bus.ex_stall = 1'b0;
        drive(1'b1, 32'h404, I_SW, 64'h41);
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL exs_release: got %b expected 0", bus.if_stall_flg);
        end
        push("exs_sw", mk(1'b1, I_SW, 32'h404, 64'h41, OPC_STORE, 5'd0, 5'd2, 5'd1, 32'd12, 1'b0), 1'b1);
        tick();
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_flush();
        bus.ex_stall = 1'b1;
        bus.branch_hazard = 1'b1;
        drive(1'b0, 32'h500, I_ADDI, 64'h50);
        push("flush", '0, 1'b0);
        tick();
        bus.ex_stall = 1'b0;
        bus.branch_hazard = 1'b0;
        drive(1'b1, 32'h504, I_LUI, 64'h51);
        push("flush_next", mk(1'b1, I_LUI, 32'h504, 64'h51, OPC_LUI, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b0), 1'b1);
        tick();
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_reset_in_bubble();
        id_t lw_e;
        lw_e = mk(1'b1, I_LW_X5, 32'h600, 64'h60, OPC_LOAD, 5'd5, 5'd2, 5'd0, 32'd0, 1'b0);
        drive(1'b1, 32'h600, I_LW_X5, 64'h60);
        push("rb_lw", lw_e, 1'b1);
        tick();
        drive(1'b1, 32'h604, I_ADD, 64'h61);
        n_checks++;
        if (bus.if_stall_flg !== 1'b1) begin
            n_errors++;
            $display("FAIL rb_stall: got %b expected 1", bus.if_stall_flg);
        end
        lw_e.valid = 1'b0;
        push("rb_bubble", lw_e, 1'b1);
        tick();
        rst = 1'b1;
        push("rb_reset", '0, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.if_stall_flg !== 1'b0) begin
            n_errors++;
            $display("FAIL rb_no_stall: got %b expected 0", bus.if_stall_flg);
        end
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h700, 32'h0000_007F, 64'h70);
        push("ill_opcode", mk(1'b1, 32'h0000_007F, 32'h700, 64'h70, OPC_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1), 1'b1);
        tick();
        drive(1'b1, 32'h704, 32'h0050_0090, 64'h71);
        push("ill_lowbits", mk(1'b1, 32'h0050_0090, 32'h704, 64'h71, OPC_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1), 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 64'd0);
        while (sb_q.size() != 0) begin
            sb_t e; id_t o;
            e = sb_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (e.full ? (o !== e.v) : (o.valid !== e.v.valid)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_back_to_back_imm();
        test_load_use();
        test_ex_stall();
        test_flush();
        test_reset_in_bubble();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
